// File: rtl/ss_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
// Contents:
//   nibble_t      - one hex digit
//   SEG_OFF       - active-low abcdefg pattern with every segment dark
//   HEX_SEG_TABLE - active-low abcdefg pattern for each hex value 0..F
package ss_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index 0 holds the pattern for hex 0, index 15 the pattern for hex F.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/ss_scan_scheduler_if.sv
// Load handshake bundle for ss_scan_scheduler.
// Signals:
//   load_valid - producer offers a new N-digit value
//   load_ready - scheduler can accept (shadow buffer empty)
//   load_data  - N hex nibbles, digit 0 in bits [3:0]
// Modports: master (value producer), slave (scheduler).
interface ss_scan_scheduler_if #(
  parameter int unsigned N = 4
);

  logic           load_valid;
  logic           load_ready;
  logic [N*4-1:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface

// File: rtl/ss_hex_decode.sv
// Combinational hex-nibble to seven-segment decoder.
// Ports:
//   nibble_i - hex value 0..F
//   seg_o    - active-low abcdefg pattern for that value
module ss_hex_decode
  import ss_pkg::*;
(
  input  nibble_t    nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/ss_scan_scheduler.sv
// Time-multiplexed scan scheduler for an N-digit common-anode seven-segment bank.
// A prescaler produces a scan tick every CLK_DIV clocks; each digit owns a slot of
// 2^BRIGHT_W ticks, and within the slot the digit is lit while the tick count is
// below the brightness code (all-ones = always lit). New values arrive through a
// valid/ready handshake into a shadow buffer and are swapped into the displayed
// buffer only at a frame boundary, so a value never tears across a frame.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   load        - slave side of the load handshake (valid/ready/data)
//   brightness  - PWM duty code, 0 = off, all-ones = 100%
//   blank       - force every digit off while scanning continues
//   displays    - active-low digit selects (registered)
//   segments    - active-low abcdefg (registered)
//   frame_start - one-cycle pulse after the digit index wraps to 0
// Build option: define SS_LEADING_ZERO_BLANK_EN to suppress leading zeros
// (digit 0 always stays eligible).
module ss_scan_scheduler
  import ss_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned BRIGHT_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  ss_scan_scheduler_if.slave  load,
  input  logic [BRIGHT_W-1:0] brightness,
  input  logic                blank,
  output logic [N-1:0]        displays,
  output logic [6:0]          segments,
  output logic                frame_start
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DigW = (N > 1) ? $clog2(N) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DigW-1:0] DigLast = DigW'(N - 1);

  logic [DivW-1:0]     div_cnt_q, div_cnt_d;
  logic [BRIGHT_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [DigW-1:0]     digit_q, digit_d;
  logic [N*4-1:0]      active_q, active_d;
  logic [N*4-1:0]      shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [N-1:0]        displays_q, displays_d;
  logic [6:0]          segments_q, segments_d;
  logic                frame_start_q, frame_start_d;

  logic       tick;
  logic       slot_end;
  logic       boundary;
  logic       xfer;
  logic       duty_on;
  logic       lz_cur;
  logic       digit_on;
  nibble_t    cur_nibble;
  logic [6:0] dec_seg;

  assign load.load_ready = ~pending_q;
  assign xfer            = load.load_valid & ~pending_q;

  // Prescaler, slot counter and digit index.
  always_comb begin
    tick      = (div_cnt_q == DivLast);
    slot_end  = tick && (sub_cnt_q == '1);
    boundary  = slot_end && (digit_q == DigLast);
    div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
    sub_cnt_d = tick ? sub_cnt_q + BRIGHT_W'(1) : sub_cnt_q;
    digit_d   = digit_q;
    if (slot_end) begin
      digit_d = (digit_q == DigLast) ? '0 : digit_q + DigW'(1);
    end
  end

  // Double buffer. A transfer needs pending_q == 0, so it can never coincide
  // with a swap; a transfer on the boundary edge waits for the next frame.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (xfer) begin
      shadow_d  = load.load_data;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    cur_nibble = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (digit_q == DigW'(i)) begin
        cur_nibble = active_q[4*i +: 4];
      end
    end
  end

`ifdef SS_LEADING_ZERO_BLANK_EN
  // lz_mask[i] is set when nibbles i..N-1 of the displayed value are all zero.
  // It depends only on active_q, so it changes only at a swap.
  logic [N-1:0] lz_mask;
  logic         zero_above;

  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = N - 1; i >= 1; i--) begin
      zero_above = zero_above & (active_q[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above;
    end
  end

  always_comb begin
    lz_cur = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (digit_q == DigW'(i)) begin
        lz_cur = lz_mask[i];
      end
    end
  end
`else
  assign lz_cur = 1'b0;
`endif

  ss_hex_decode u_hex_decode (
    .nibble_i (cur_nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
    duty_on       = (sub_cnt_q < brightness) || (brightness == '1);
    digit_on      = duty_on && !blank && !lz_cur;
    displays_d    = digit_on ? ~(N'(1) << digit_q) : '1;
    segments_d    = digit_on ? dec_seg : SEG_OFF;
    frame_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q     <= '0;
      sub_cnt_q     <= '0;
      digit_q       <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      displays_q    <= '1;
      segments_q    <= SEG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      sub_cnt_q     <= sub_cnt_d;
      digit_q       <= digit_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      displays_q    <= displays_d;
      segments_q    <= segments_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign displays    = displays_q;
  assign segments    = segments_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ss_scan_scheduler.sv
// Directed bench for ss_scan_scheduler with N=4, CLK_DIV=4, BRIGHT_W=2
// (slot = 16 clocks, frame = 64 clocks). Honours SS_LEADING_ZERO_BLANK_EN.
module tb_ss_scan_scheduler;

  localparam int unsigned N        = 4;
  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned BRIGHT_W = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] brightness;
  logic       blank;
  logic [3:0] displays;
  logic [6:0] segments;
  logic       frame_start;

  int vectors     = 0;
  int miscompares = 0;
  int cycles;

  logic [6:0] seg_tbl [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  ss_scan_scheduler_if #(.N(N)) load_if ();

  ss_scan_scheduler #(
    .N        (N),
    .CLK_DIV  (CLK_DIV),
    .BRIGHT_W (BRIGHT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load_if),
    .brightness  (brightness),
    .blank       (blank),
    .displays    (displays),
    .segments    (segments),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic lz_off(input logic [15:0] v, input int d);
`ifdef SS_LEADING_ZERO_BLANK_EN
    logic [15:0] t;
    if (d == 0) return 1'b0;
    t = v >> (4 * d);
    return (t == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Returns at the negedge of the cycle in which frame_start is high.
  task automatic wait_frame(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 200);
    if (frame_start !== 1'b1) chk({tag, "_timeout"}, 32'(frame_start), 32'd1);
  endtask

  // Called at the frame_start negedge; checks the 64 output cycles of the next
  // frame and ends at the following frame_start negedge. With late=1 a transfer
  // is offered on exactly the digit N-1 -> 0 edge.
  task automatic check_frame(input string tag, input logic [15:0] val, input logic [1:0] br,
                             input logic blk, input logic late, input logic [15:0] late_data);
    int         d;
    int         sub;
    logic       on;
    logic [3:0] exp_disp;
    logic [6:0] exp_seg;
    logic [3:0] nib;
    for (int s = 0; s < 64; s++) begin
      @(negedge clk);
      if (s == 0 || s == 63) load_if.load_valid = 1'b0;
      if (s == 62 && late) begin
        load_if.load_valid = 1'b1;
        load_if.load_data  = late_data;
      end
      d        = s / 16;
      sub      = (s % 16) / 4;
      on       = (br == 2'd3 || sub < int'(br)) && !blk && !lz_off(val, d);
      nib      = val[4*d +: 4];
      exp_disp = on ? ~(4'b0001 << d) : 4'hF;
      exp_seg  = on ? seg_tbl[nib] : 7'h7F;
      chk($sformatf("%s_disp_s%0d", tag, s), 32'(displays), 32'(exp_disp));
      chk($sformatf("%s_seg_s%0d", tag, s), 32'(segments), 32'(exp_seg));
      chk($sformatf("%s_fs_s%0d", tag, s), 32'(frame_start), 32'(s == 63));
    end
  endtask

  initial begin
    brightness         = 2'd3;
    blank              = 1'b0;
    load_if.load_valid = 1'b0;
    load_if.load_data  = 16'h0;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst0_disp", 32'(displays), 32'hF);
    chk("rst0_seg", 32'(segments), 32'h7F);
    chk("rst0_ready", 32'(load_if.load_ready), 32'd1);
    chk("rst0_fs", 32'(frame_start), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold_disp", 32'(displays), 32'hF);
    chk("rst_hold_seg", 32'(segments), 32'h7F);
    rst = 1'b1;

    // Scanning starts at digit 0 showing the zero value.
    @(negedge clk);
    chk("start_disp", 32'(displays), 32'hE);
    chk("start_seg", 32'(segments), 32'h01);
    wait_frame("first_frame", cycles);
    chk("first_frame_cycles", 32'(cycles), 32'd63);
    check_frame("zero", 16'h0000, 2'd3, 1'b0, 1'b0, 16'h0);

    // Load 1234 just after a boundary; it swaps in at the next one.
    load_if.load_valid = 1'b1;
    load_if.load_data  = 16'h1234;
    @(negedge clk);
    load_if.load_valid = 1'b0;
    load_if.load_data  = 16'hDEAD;
    chk("load1234_ready", 32'(load_if.load_ready), 32'd0);
    wait_frame("swap1234", cycles);
    chk("swap1234_cycles", 32'(cycles), 32'd63);
    chk("swap1234_ready", 32'(load_if.load_ready), 32'd1);
    check_frame("v1234_b3", 16'h1234, 2'd3, 1'b0, 1'b0, 16'h0);

    // Brightness and blank.
    brightness = 2'd1;
    check_frame("v1234_b1", 16'h1234, 2'd1, 1'b0, 1'b0, 16'h0);
    brightness = 2'd0;
    check_frame("v1234_b0", 16'h1234, 2'd0, 1'b0, 1'b0, 16'h0);
    brightness = 2'd3;
    blank      = 1'b1;
    check_frame("v1234_blank", 16'h1234, 2'd3, 1'b1, 1'b0, 16'h0);
    blank      = 1'b0;

    // Back-pressure: 2222 held while 1111 is pending.
    load_if.load_valid = 1'b1;
    load_if.load_data  = 16'h1111;
    @(negedge clk);
    chk("load1111_ready", 32'(load_if.load_ready), 32'd0);
    load_if.load_data = 16'h2222;
    repeat (10) @(negedge clk);
    chk("hold2222_ready", 32'(load_if.load_ready), 32'd0);
    wait_frame("swap1111", cycles);
    chk("swap1111_ready", 32'(load_if.load_ready), 32'd1);
    check_frame("v1111", 16'h1111, 2'd3, 1'b0, 1'b0, 16'h0);
    chk("swap2222_ready", 32'(load_if.load_ready), 32'd1);
    check_frame("v2222", 16'h2222, 2'd3, 1'b0, 1'b0, 16'h0);

    // Transfer on the boundary edge itself goes to shadow only.
    check_frame("v2222_late", 16'h2222, 2'd3, 1'b0, 1'b1, 16'h00A0);
    chk("late_ready", 32'(load_if.load_ready), 32'd0);
    check_frame("v2222_kept", 16'h2222, 2'd3, 1'b0, 1'b0, 16'h0);
    check_frame("v00a0", 16'h00A0, 2'd3, 1'b0, 1'b0, 16'h0);

    // Asynchronous reset mid-frame, away from any clock edge.
    repeat (20) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst1_disp", 32'(displays), 32'hF);
    chk("rst1_seg", 32'(segments), 32'h7F);
    chk("rst1_ready", 32'(load_if.load_ready), 32'd1);
    chk("rst1_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_disp", 32'(displays), 32'hE);
    chk("restart_seg", 32'(segments), 32'h01);
    wait_frame("restart_frame", cycles);
    chk("restart_frame_cycles", 32'(cycles), 32'd63);
    check_frame("zero_again", 16'h0000, 2'd3, 1'b0, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
